seg7_scroll_mux: RTL and testbench

//  Multi-digit 7-segment display engine; generalises the single-digit 7-seg output to N multiplexed digits.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_glyph_rom.sv | 34 +++
 rtl/seg7_scroll_mux.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scroll_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph codes, display modes and segment constants for the
// multiplexed 7-segment scroll engine.
package seg7_pkg;

  localparam logic [4:0] GLYPH_BLANK = 5'h10;
  localparam logic [4:0] GLYPH_MINUS = 5'h11;
  localparam logic [4:0] GLYPH_UNDER = 5'h12;

  // Segment order is {g,f,e,d,c,b,a}; active-high before output inversion.
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph decoder: 5-bit glyph code to {g,f,e,d,c,b,a} pattern.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      5'h00:       pattern = 7'h3F;
      5'h01:       pattern = 7'h06;
      5'h02:       pattern = 7'h5B;
      5'h03:       pattern = 7'h4F;
      5'h04:       pattern = 7'h66;
      5'h05:       pattern = 7'h6D;
      5'h06:       pattern = 7'h7D;
      5'h07:       pattern = 7'h07;
      5'h08:       pattern = 7'h7F;
      5'h09:       pattern = 7'h6F;
      5'h0A:       pattern = 7'h77;
      5'h0B:       pattern = 7'h7C;
      5'h0C:       pattern = 7'h39;
      5'h0D:       pattern = 7'h5E;
      5'h0E:       pattern = 7'h79;
      5'h0F:       pattern = 7'h71;
      GLYPH_MINUS: pattern = 7'h40;
      GLYPH_UNDER: pattern = 7'h08;
      default:     pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scroll_mux.sv
// Multi-digit 7-segment engine: message buffer, refresh/frame timing chain,
// offset/direction FSM for scroll, bounce and blink, and registered outputs.
module seg7_scroll_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_DEPTH     = 16,
  parameter int REFRESH_DIV   = 1000,
  parameter int SCROLL_FRAMES = 250,
  parameter int ACTIVE_LOW    = 0,
  localparam int LEN_W        = $clog2(MSG_DEPTH) + 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_en,
  input  logic [4:0]            wr_char,
  input  logic                  clear,
  input  logic [1:0]            mode,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [LEN_W-1:0]      msg_len,
  output logic                  msg_full
);

  localparam int PTR_W = $clog2(MSG_DEPTH);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int FR_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int IDX_W = LEN_W + 1;

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(SCROLL_FRAMES - 1);
  localparam logic [LEN_W-1:0] ND_LEN   = LEN_W'(NUM_DIGITS);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MSG_DEPTH);
  localparam logic             OUT_INV  = (ACTIVE_LOW != 0);

  logic [4:0]            msg_buf [MSG_DEPTH];
  logic                  buf_wr;

  logic [REF_W-1:0]      ref_cnt;
  logic [DIG_W-1:0]      digit_idx;
  logic [FR_W-1:0]       frame_cnt;
  logic                  ref_wrap, digit_wrap, frame_wrap, step;

  mode_t                 mode_cur, mode_q;
  logic                  mode_chg;
  logic [PTR_W-1:0]      offset, offset_nxt;
  dir_t                  dir, dir_nxt;
  logic                  blink_phase, blink_nxt;
  logic                  multi_page;
  logic [LEN_W-1:0]      span;

  logic [IDX_W-1:0]      idx_raw, idx_wrap;
  logic                  digit_blank;
  logic [4:0]            char_code;
  logic [6:0]            glyph_seg;
  logic [6:0]            seg_p0;
  logic [NUM_DIGITS-1:0] sel_p0;
  logic                  dp_p0;

  // Message buffer: writes are independent of ena; clear beats a write.
  assign msg_full = (msg_len == FULL_LEN);
  assign buf_wr   = wr_en && !clear && !msg_full;

  always_ff @(posedge clk) begin
    if (buf_wr) msg_buf[PTR_W'(msg_len)] <= wr_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      msg_len <= '0;
    else if (clear)  msg_len <= '0;
    else if (buf_wr) msg_len <= msg_len + 1'b1;
  end

  // Timing chain: slot -> frame -> step
  assign ref_wrap   = (ref_cnt == REF_LAST);
  assign digit_wrap = (digit_idx == DIG_LAST);
  assign frame_wrap = (frame_cnt == FR_LAST);
  assign step       = ena && ref_wrap && digit_wrap && frame_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
    end else begin
      if (ena) begin
        ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
        if (ref_wrap) digit_idx <= digit_wrap ? '0 : digit_idx + 1'b1;
      end
      // A mode change restarts the step period without disturbing the scan.
      if (mode_chg)
        frame_cnt <= '0;
      else if (ena && ref_wrap && digit_wrap)
        frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
    end
  end

  // Offset / direction / blink FSM
  assign mode_cur   = mode_t'(mode);
  assign mode_chg   = (mode_cur != mode_q);
  assign multi_page = (msg_len > ND_LEN);
  assign span       = msg_len - ND_LEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset      <= '0;
      dir         <= DIR_UP;
      blink_phase <= 1'b0;
      mode_q      <= MODE_STATIC;
    end else begin
      offset      <= offset_nxt;
      dir         <= dir_nxt;
      blink_phase <= blink_nxt;
      mode_q      <= mode_cur;
    end
  end

  always_comb begin
    offset_nxt = offset;
    dir_nxt    = dir;
    blink_nxt  = blink_phase;
    if (mode_chg) begin
      offset_nxt = '0;
      dir_nxt    = DIR_UP;
      blink_nxt  = 1'b0;
    end else if (clear) begin
      offset_nxt = '0;
    end else if (step) begin
      case (mode_cur)
        MODE_STATIC: offset_nxt = '0;
        MODE_SCROLL: begin
          if (!multi_page || ({1'b0, offset} == msg_len - 1'b1)) offset_nxt = '0;
          else                                                   offset_nxt = offset + 1'b1;
        end
        MODE_BOUNCE: begin
          if (!multi_page) begin
            offset_nxt = '0;
            dir_nxt    = DIR_UP;
          end else if (dir == DIR_UP) begin
            // Reversal and the first move back happen on the same step.
            if ({1'b0, offset} >= span) begin
              dir_nxt    = DIR_DOWN;
              offset_nxt = offset - 1'b1;
            end else begin
              offset_nxt = offset + 1'b1;
            end
          end else begin
            if (offset == '0) begin
              dir_nxt    = DIR_UP;
              offset_nxt = offset + 1'b1;
            end else begin
              offset_nxt = offset - 1'b1;
            end
          end
        end
        MODE_BLINK: begin
          offset_nxt = '0;
          blink_nxt  = !blink_phase;
        end
      endcase
    end
  end

  // Character select for the digit currently being scanned
  assign idx_raw     = IDX_W'(offset) + IDX_W'(digit_idx);
  assign idx_wrap    = (idx_raw >= IDX_W'(msg_len)) ? idx_raw - IDX_W'(msg_len) : idx_raw;
  assign digit_blank = (IDX_W'(digit_idx) >= IDX_W'(msg_len));
  assign char_code   = digit_blank ? GLYPH_BLANK : msg_buf[PTR_W'(idx_wrap)];

  seg7_glyph_rom u_glyph_rom (
    .code    (char_code),
    .pattern (glyph_seg)
  );

  assign seg_p0 = blink_phase ? SEG_OFF : glyph_seg;
  assign sel_p0 = ref_wrap ? '0 : (NUM_DIGITS'(1) << digit_idx);
  assign dp_p0  = msg_full && (digit_idx == '0) && !ref_wrap;

  // Output register: one cycle behind digit_idx, polarity applied here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments  <= {7{OUT_INV}} ^ SEG_OFF;
      digit_sel <= {NUM_DIGITS{OUT_INV}};
      dp        <= OUT_INV;
    end else if (!ena) begin
      segments  <= {7{OUT_INV}} ^ SEG_OFF;
      digit_sel <= {NUM_DIGITS{OUT_INV}};
      dp        <= OUT_INV;
    end else begin
      segments  <= {7{OUT_INV}} ^ seg_p0;
      digit_sel <= {NUM_DIGITS{OUT_INV}} ^ sel_p0;
      dp        <= OUT_INV ^ dp_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scroll_mux.sv
// Directed bench for seg7_scroll_mux with 4 digits, 8-entry buffer,
// 4-cycle slots and 2 frames per step (one step every 32 enabled cycles).
module tb_seg7_scroll_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       wr_en;
  logic [4:0] wr_char;
  logic       clear;
  logic [1:0] mode;
  logic [6:0] segments;
  logic       dp;
  logic [3:0] digit_sel;
  logic [3:0] msg_len;
  logic       msg_full;

  int total = 0;
  int bad   = 0;
  int ena_cycles;

  seg7_scroll_mux #(
    .NUM_DIGITS    (4),
    .MSG_DEPTH     (8),
    .REFRESH_DIV   (4),
    .SCROLL_FRAMES (2),
    .ACTIVE_LOW    (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_en     (wr_en),
    .wr_char   (wr_char),
    .clear     (clear),
    .mode      (mode),
    .segments  (segments),
    .dp        (dp),
    .digit_sel (digit_sel),
    .msg_len   (msg_len),
    .msg_full  (msg_full)
  );

  always #5 clk = ~clk;

  // Independent count of enabled clock edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ena_cycles <= 0;
    else if (ena) ena_cycles <= ena_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; clear = 1'b0; wr_char = 5'h0; mode = m;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [4:0] c);
    @(negedge clk);
    wr_en = 1'b1; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    ena = 1'b1;
  endtask

  task automatic wait_cycle(input int target, input string tag);
    int guard = 0;
    while (ena_cycles < target && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(tag, ena_cycles, target);
  endtask

  task automatic check_digit(input int i, input logic [6:0] s, input logic d, input string tag);
    int guard = 0;
    logic [3:0] want;
    want = 4'b0001 << i;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (digit_sel !== want && guard < 40);
    chk($sformatf("%s_sel%0d", tag, i), 32'(digit_sel), 32'(want));
    chk($sformatf("%s_seg%0d", tag, i), 32'(segments), 32'(s));
    chk($sformatf("%s_dp%0d", tag, i), 32'(dp), 32'(d));
  endtask

  task automatic check_digits(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic d0, input string tag);
    check_digit(0, s0, d0, tag);
    check_digit(1, s1, 1'b0, tag);
    check_digit(2, s2, 1'b0, tag);
    check_digit(3, s3, 1'b0, tag);
  endtask

  initial begin
    int zeros;
    int n;
    logic [3:0] exp_sel;

    // Reset state and first strobe after release
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; clear = 1'b0; wr_char = 5'h0; mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(segments), 32'h0);
    chk("rst_sel", 32'(digit_sel), 32'h0);
    chk("rst_len", 32'(msg_len), 32'h0);
    chk("rst_full", 32'(msg_full), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rel_sel", 32'(digit_sel), 32'b0001);
    chk("rel_seg", 32'(segments), 32'h0);

    // Static display and anti-ghosting blank slot
    do_reset(2'b00);
    wr(5'h1); wr(5'h2); wr(5'h3); wr(5'h4);
    chk("st_len", 32'(msg_len), 32'd4);
    go();
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "st");
    zeros = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (digit_sel == 4'b0000) zeros++;
    end
    chk("st_blank_slots", zeros, 2);

    // Scroll: 6 chars, wrap after 6 steps
    do_reset(2'b01);
    for (int c = 0; c < 6; c++) wr(5'(c));
    go();
    check_digits(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0, "sc0");
    wait_cycle(32, "sc_wait1");
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "sc1");
    wait_cycle(96, "sc_wait3");
    check_digits(7'h4F, 7'h66, 7'h6D, 7'h3F, 1'b0, "sc3");
    wait_cycle(192, "sc_wait6");
    check_digits(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0, "sc6");

    // Bounce: offsets 1,2,1,0,1 on steps 1..5
    do_reset(2'b10);
    for (int c = 0; c < 6; c++) wr(5'(c));
    go();
    wait_cycle(32, "bn_wait1");
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "bn1");
    wait_cycle(64, "bn_wait2");
    check_digits(7'h5B, 7'h4F, 7'h66, 7'h6D, 1'b0, "bn2");
    wait_cycle(96, "bn_wait3");
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "bn3");
    wait_cycle(128, "bn_wait4");
    check_digits(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0, "bn4");
    wait_cycle(160, "bn_wait5");
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "bn5");

    // Full buffer, dp, clear priority, special glyphs
    do_reset(2'b00);
    for (int c = 0; c < 9; c++) wr(5'(c));
    chk("full_len", 32'(msg_len), 32'd8);
    chk("full_flag", 32'(msg_full), 32'h1);
    go();
    check_digits(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b1, "full");
    @(negedge clk);
    clear = 1'b1; wr_en = 1'b1; wr_char = 5'h07;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    chk("clr_len", 32'(msg_len), 32'h0);
    chk("clr_full", 32'(msg_full), 32'h0);
    check_digits(7'h00, 7'h00, 7'h00, 7'h00, 1'b0, "clr");
    wr(5'h11); wr(5'h12); wr(5'h0A); wr(5'h1F);
    chk("gl_len", 32'(msg_len), 32'd4);
    check_digits(7'h40, 7'h08, 7'h77, 7'h00, 1'b0, "gl");

    // Blink phases, then ena freeze/resume
    do_reset(2'b11);
    wr(5'h1); wr(5'h2); wr(5'h3); wr(5'h4);
    go();
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "bk0");
    wait_cycle(32, "bk_wait1");
    check_digits(7'h00, 7'h00, 7'h00, 7'h00, 1'b0, "bk1");
    wait_cycle(64, "bk_wait2");
    check_digits(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, "bk2");
    @(negedge clk);
    ena = 1'b0;
    n = ena_cycles;
    @(posedge clk); #1;
    chk("ena_off_seg", 32'(segments), 32'h0);
    chk("ena_off_sel", 32'(digit_sel), 32'h0);
    chk("ena_off_dp", 32'(dp), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("ena_hold_sel", 32'(digit_sel), 32'h0);
    @(negedge clk);
    ena = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      exp_sel = (((n + k) % 4) == 3) ? 4'b0000 : (4'b0001 << (((n + k) / 4) % 4));
      chk($sformatf("ena_resume%0d", k), 32'(digit_sel), 32'(exp_sel));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
